dff_ram_dp: RTL and testbench

//   Parametrised simple-dual-port flip-flop RAM with one write port and one read port.

---
 rtl/dff_ram_pkg.sv | 38 +++
 rtl/dff_ram_rd_pipe.sv | 63 ++++++
 rtl/dff_ram_dp.sv | 111 +++++++++++
 tb/tb_dff_ram_dp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dff_ram_pkg.sv
// ============================================================================
//  Module      : dff_ram_pkg
//  Description : Shared lane width, FSM state type and byte-merge helper for
//                the flip-flop dual-port RAM.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package dff_ram_pkg;

    localparam int LANE_W = 8;
    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_W  = 1024;
    localparam int MAX_BE = MAX_W / LANE_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0]  old_word,
        input logic [MAX_W-1:0]  new_word,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) begin
                merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dff_ram_rd_pipe.sv
// ============================================================================
//  Module      : dff_ram_rd_pipe
//  Description : Read result register plus optional output stage (OUT_REG).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module dff_ram_rd_pipe #(
    parameter int DATA_W  = 72,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;

    // Data only moves on a valid result so the output holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_s2_valid;
            logic [DATA_W-1:0] r_s2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign out_valid = r_s2_valid;
            assign out_data  = r_s2_data;
        end else begin : g_no_out_reg
            assign out_valid = r_s1_valid;
            assign out_data  = r_s1_data;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dff_ram_dp.sv
// ============================================================================
//  Module      : dff_ram_dp
//  Description : Simple-dual-port flip-flop RAM with byte enables and a clear
//                engine. Define DFF_RAM_BYPASS_EN for write-to-read bypass.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module dff_ram_dp
    import dff_ram_pkg::*;
#(
    parameter int DATA_W  = 72,
    parameter int ADDR_W  = 2,
    parameter int OUT_REG = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    output logic                   ready,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W/8-1:0]    wr_be,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [DATA_W-1:0]      r_data,
    output logic                   r_valid
);

    localparam int              c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_cnt_last = ADDR_W'(c_depth - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [c_depth];

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [DATA_W-1:0] w_wr_merged;
    logic [DATA_W-1:0] w_rd_word;

    assign ready     = (r_state == ST_RUN);
    assign w_wr_fire = ready & wr_en;
    assign w_rd_fire = ready & rd_en;

    assign w_wr_merged = DATA_W'(be_merge(MAX_W'(r_mem[wr_addr]),
                                          MAX_W'(wr_data),
                                          MAX_BE'(wr_be)));

`ifdef DFF_RAM_BYPASS_EN
    // Same-address collision: the merged write word is exactly the new contents.
    assign w_rd_word = (w_wr_fire && (wr_addr == rd_addr)) ? w_wr_merged
                                                           : r_mem[rd_addr];
`else
    assign w_rd_word = r_mem[rd_addr];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (clr) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                        if (r_cnt == c_cnt_last) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the clear engine owns initialisation.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_fire) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

    dff_ram_rd_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_rd_fire),
        .in_data   (w_rd_word),
        .out_valid (r_valid),
        .out_data  (r_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_dff_ram_dp.sv
// ============================================================================
//  Module      : tb_dff_ram_dp
//  Description : Directed self-checking bench; OUT_REG=0 and OUT_REG=1 copies
//                share one stimulus.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dff_ram_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [71:0] wr_data;
    logic [8:0]  wr_be;
    logic        rd_en;
    logic [1:0]  rd_addr;

    logic        ready0, r_valid0, ready1, r_valid1;
    logic [71:0] r_data0, r_data1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dff_ram_dp #(.DATA_W(72), .ADDR_W(2), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data0), .r_valid(r_valid0)
    );

    dff_ram_dp #(.DATA_W(72), .ADDR_W(2), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data1), .r_valid(r_valid1)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready0 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 72'(n), 72'd4);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [71:0] d, input logic [8:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [1:0] a, input logic [71:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 72'(r_valid0), 72'd1);
        check({tag, "_data"}, r_data0, exp);
    endtask

    function automatic logic [71:0] word_of(input int i);
        return {8'hC0 + 8'(i), 64'hDEAD_BEEF_0000_0000 + 64'(i)};
    endfunction

    initial begin
        logic [71:0] coll_exp;

        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_be = '0; rd_en = 1'b0; rd_addr = '0;

        // Reset state and initial clear length
        repeat (3) tick();
        check("rst_ready",  72'(ready0),   72'd0);
        check("rst_valid0", 72'(r_valid0), 72'd0);
        check("rst_data0",  r_data0,       72'd0);
        check("rst_valid1", 72'(r_valid1), 72'd0);
        check("rst_data1",  r_data1,       72'd0);
        rst = 1'b0;
        wait_ready("init_clear_len");
        for (int i = 0; i < 4; i++) do_read("init_rd", 2'(i), 72'd0);

        // Byte-enable merge
        do_write(2'd2, 72'hFF_0123456789ABCDEF, 9'h1FF);
        do_write(2'd2, 72'h00_FFFFFFFFFFFFFFFF, 9'h001);
        do_read("be_merge", 2'd2, 72'hFF_0123456789ABCDFF);
        do_write(2'd3, 72'h11_2233445566778899, 9'h1FF);
        do_write(2'd3, 72'hAA_BBCCDDEEFF001122, 9'h102);
        do_read("be_mix", 2'd3, 72'hAA_223344556677_1199);
        do_write(2'd3, 72'hFF_FFFFFFFFFFFFFFFF, 9'h000);
        do_read("be_zero", 2'd3, 72'hAA_223344556677_1199);

        // Same-cycle read/write collision
`ifdef DFF_RAM_BYPASS_EN
        coll_exp = 72'h5A;
`else
        coll_exp = 72'h0;
`endif
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 72'h5A; wr_be = 9'h1FF;
        rd_en = 1'b1; rd_addr = 2'd1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("coll_valid", 72'(r_valid0), 72'd1);
        check("coll_data", r_data0, coll_exp);
        do_read("coll_after", 2'd1, 72'h5A);

        // Back-to-back reads; OUT_REG=1 copy trails by one cycle
        for (int i = 0; i < 4; i++) do_write(2'(i), word_of(i), 9'h1FF);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = 2'(i);
            tick();
            check("b2b_valid0", 72'(r_valid0), 72'd1);
            check("b2b_data0", r_data0, word_of(i));
            if (i == 0) begin
                check("b2b_lat1", 72'(r_valid1), 72'd0);
            end else begin
                check("b2b_valid1", 72'(r_valid1), 72'd1);
                check("b2b_data1", r_data1, word_of(i - 1));
            end
        end
        rd_en = 1'b0;
        tick();
        check("b2b_end0", 72'(r_valid0), 72'd0);
        check("b2b_valid1", 72'(r_valid1), 72'd1);
        check("b2b_data1", r_data1, word_of(3));
        tick();
        check("b2b_end1", 72'(r_valid1), 72'd0);
        check("b2b_hold1", r_data1, word_of(3));

        // clr pulse: requests during clear are dropped, memory zeroed
        for (int i = 0; i < 4; i++) do_write(2'(i), 72'hA5A5A5A5A5A5A5A5A5, 9'h1FF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ready", 72'(ready0), 72'd0);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 72'hFF_FFFFFFFFFFFFFFFF; wr_be = 9'h1FF;
        rd_en = 1'b1; rd_addr = 2'd2;
        tick();
        rd_en = 1'b0;
        check("clr_rd_drop", 72'(r_valid0), 72'd0);
        tick();
        wr_en = 1'b0;
        begin
            int n;
            n = 2;
            while (!ready0 && n < 20) begin
                tick();
                n++;
            end
            check("clr_len", 72'(n), 72'd4);
        end
        for (int i = 0; i < 4; i++) do_read("clr_rd", 2'(i), 72'd0);

        // Reset while clear counter is at 2
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midclr_rst_ready", 72'(ready0), 72'd0);
        tick();
        rst = 1'b0;
        wait_ready("midclr_rst_len");

        // Asynchronous reset out of RUN clears outputs without a clock edge
        do_write(2'd1, 72'h5A, 9'h1FF);
        do_read("pre_async", 2'd1, 72'h5A);
        #2;
        rst = 1'b1;
        #1;
        check("async_ready", 72'(ready0), 72'd0);
        check("async_data0", r_data0, 72'd0);
        tick();
        rst = 1'b0;
        wait_ready("async_clear_len");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
